// File: rtl/dcache_refill_if.sv
// dcache_refill_if: miss-request, AXI read and data-RAM write bundle for the line-refill engine
// master: the refill engine (drives req_ready, AR channel, rready, RAM write port, crit/done/err)
// slave : the environment (drives req_valid/req_addr, arready, R channel)
interface dcache_refill_if #(parameter int LINE_WORDS = 8);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_addr;
    logic [3:0]            arid;
    logic [31:0]           araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    logic                  ram_en;
    logic [3:0]            ram_wen;
    logic [LINE_WORDS-1:0] ram_bank;
    logic [31:0]           ram_addr;
    logic [31:0]           ram_wdata;
    logic                  crit_valid;
    logic [31:0]           crit_data;
    logic                  done;
    logic                  err;

    modport master (
        input  req_valid, req_addr, arready, rdata, rresp, rlast, rvalid,
        output req_ready, arid, araddr, arlen, arsize, arburst, arvalid, rready,
               ram_en, ram_wen, ram_bank, ram_addr, ram_wdata, crit_valid, crit_data, done, err
    );

    modport slave (
        output req_valid, req_addr, arready, rdata, rresp, rlast, rvalid,
        input  req_ready, arid, araddr, arlen, arsize, arburst, arvalid, rready,
               ram_en, ram_wen, ram_bank, ram_addr, ram_wdata, crit_valid, crit_data, done, err
    );
endinterface

// File: rtl/dcache_refill.sv
// dcache_refill: data-cache line refill via one AXI INCR read burst into per-word RAM banks
// clk    : system clock, rising edge
// resetn : asynchronous active-low reset, aborts any burst in flight
// bus    : dcache_refill_if.master -- miss request, AXI AR/R channels, RAM write port,
//          critical-word forward, done/err completion
// Define CRIT_WORD_FWD_EN to forward the critical word early; otherwise crit_valid/crit_data are 0.
module dcache_refill #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'd1
) (
    input logic             clk,
    input logic             resetn,
    dcache_refill_if.master bus
);
    localparam int CW = $clog2(LINE_WORDS);
    localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
    localparam logic [LINE_WORDS-1:0] ONE = LINE_WORDS'(1);

    typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:5]   line_q, line_n;
    logic          err_q, err_n;
    logic          ovf_q, ovf_n;
    logic          beat, wr;

    // ovf_q: a full line was written but rlast has not arrived; further beats are drained unwritten
    assign beat = state == R && bus.rvalid;
    assign wr   = beat && !ovf_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            line_q <= '0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            line_q <= line_n;
            err_q  <= err_n;
            ovf_q  <= ovf_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        line_n  = line_q;
        err_n   = err_q;
        ovf_n   = ovf_q;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_n = AR;
                line_n  = bus.req_addr[31:5];
                cnt_n   = '0;
                err_n   = 1'b0;
                ovf_n   = 1'b0;
            end
            AR: if (bus.arready) state_n = R;
            R: if (beat) begin
                err_n = err_q | (bus.rresp != 2'b00);
                if (bus.rlast) begin
                    state_n = DONE;
                    if (!ovf_q && cnt != LAST) err_n = 1'b1;
                end else if (!ovf_q && cnt == LAST) begin
                    err_n = 1'b1;
                    ovf_n = 1'b1;
                end
                if (wr && cnt != LAST) cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.req_ready = state == IDLE;
    assign bus.arid      = AXI_ID;
    assign bus.araddr    = {line_q, 5'b0};
    assign bus.arlen     = 8'(LINE_WORDS - 1);
    assign bus.arsize    = 3'b010;
    assign bus.arburst   = 2'b01;
    assign bus.arvalid   = state == AR;
    assign bus.rready    = state == R;
    assign bus.ram_en    = wr;
    assign bus.ram_wen   = wr ? 4'hF : 4'h0;
    assign bus.ram_bank  = wr ? ONE << cnt : '0;
    assign bus.ram_addr  = {line_q, 5'b0};
    assign bus.ram_wdata = bus.rdata;
    assign bus.done      = state == DONE;
    assign bus.err       = state == DONE && err_q;

`ifdef CRIT_WORD_FWD_EN
    logic [CW-1:0] crit_idx;
    logic          crit_q;
    logic [31:0]   crit_d;
    logic          crit_hit;

    assign crit_hit = wr && cnt == crit_idx;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crit_idx <= '0;
            crit_q   <= 1'b0;
            crit_d   <= '0;
        end else begin
            if (state == IDLE && bus.req_valid) crit_idx <= bus.req_addr[2 +: CW];
            crit_q <= crit_hit;
            if (crit_hit) crit_d <= bus.rdata;
        end
    end

    assign bus.crit_valid = crit_q;
    assign bus.crit_data  = crit_d;
`else
    assign bus.crit_valid = 1'b0;
    assign bus.crit_data  = '0;
`endif
endmodule
